// File: rtl/tdm_pkg.sv
// Shared definitions for the time-division channel multiplexer and the
// neuron timing blocks: mode encodings and a constant width helper.
package tdm_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  // Bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tdm_dwell_counter.sv
// Slot dwell counter: counts 0..SLOT_CYCLES-1, flags eligibility at the
// terminal count, and holds there while 'hold' is asserted.
module tdm_dwell_counter
  import tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic hold,
  output logic eligible
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign eligible = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (!eligible) begin
        cnt <= cnt + 1'b1;
      end else if (!hold) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tdm_chan_mux.sv
// Registered N-channel TDM multiplexer with valid/ready output, channel tag
// and frame marker; round-robin scan or fixed-channel sampling.
module tdm_chan_mux
  import tdm_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int NUM_CH      = 4,
  parameter  int SLOT_CYCLES = 1,
  localparam int CH_W        = clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    mode,
  input  logic [CH_W-1:0]         sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_start
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]  slot;
  logic [CH_W-1:0]  chan;
  logic [WIDTH-1:0] cap_data;
  logic             eligible;
  logic             slot_free;
  logic             stall;
  logic             capture;
  logic             consume;

  assign slot_free = !out_valid || out_ready;
  assign stall     = !slot_free;
  assign capture   = ena && eligible && slot_free;
  assign consume   = ena && out_valid && out_ready;
  assign chan      = (mode == MODE_SCAN) ? slot : sel;

  tdm_dwell_counter #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .hold     (stall),
    .eligible (eligible)
  );

  // Out-of-range indices (non-power-of-2 NUM_CH) match no channel and read 0.
  // NOTE: the default before the loop keeps this block free of latches.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chan == CH_W'(k)) cap_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Fixed-mode captures park the slot at 0 so scan always restarts at ch0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (capture) begin
      slot <= (mode == MODE_SCAN && slot != LAST_CH) ? slot + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (capture) begin
      out_data    <= cap_data;
      out_ch      <= chan;
      out_valid   <= 1'b1;
      frame_start <= (mode == MODE_SCAN) && (chan == '0);
    end else if (consume) begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_chan_mux.sv
// Bench for tdm_chan_mux: three configurations (4ch/1, 4ch/3 dwell, 3ch/1)
// driven in lockstep and compared every cycle against a behavioural model.
module tb_tdm_chan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        mode;
  logic [1:0]  sel;
  logic        out_ready;
  logic [31:0] in_data;

  logic [7:0] o_data  [3];
  logic [1:0] o_ch    [3];
  logic       o_valid [3];
  logic       o_fs    [3];

  int total = 0;
  int bad   = 0;

  int nc [3] = '{4, 4, 3};
  int sc [3] = '{1, 3, 1};

  // Reference model: one entry per instance.
  logic [7:0] m_data  [3];
  logic [1:0] m_ch    [3];
  logic       m_valid [3];
  logic       m_fs    [3];
  int         m_pos   [3];
  int         m_wait  [3];

  always #5 clk = ~clk;

  tdm_chan_mux #(.WIDTH(8), .NUM_CH(4), .SLOT_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .sel(sel),
    .in_data(in_data), .out_data(o_data[0]), .out_ch(o_ch[0]),
    .out_valid(o_valid[0]), .out_ready(out_ready), .frame_start(o_fs[0]));

  tdm_chan_mux #(.WIDTH(8), .NUM_CH(4), .SLOT_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .sel(sel),
    .in_data(in_data), .out_data(o_data[1]), .out_ch(o_ch[1]),
    .out_valid(o_valid[1]), .out_ready(out_ready), .frame_start(o_fs[1]));

  tdm_chan_mux #(.WIDTH(8), .NUM_CH(3), .SLOT_CYCLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .sel(sel),
    .in_data(in_data[23:0]), .out_data(o_data[2]), .out_ch(o_ch[2]),
    .out_valid(o_valid[2]), .out_ready(out_ready), .frame_start(o_fs[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_data[i] = '0; m_ch[i] = '0; m_valid[i] = 1'b0; m_fs[i] = 1'b0;
      m_pos[i] = 0; m_wait[i] = 0;
    end
  endtask

  // One clock edge of the behavioural model, using inputs as seen at the edge.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit free, elig;
      int c;
      if (!ena) continue;
      free = !m_valid[i] || out_ready;
      elig = (m_wait[i] >= sc[i] - 1);
      if (elig && free) begin
        c          = mode ? m_pos[i] : int'(sel);
        m_data[i]  = (c < nc[i]) ? in_data[c*8 +: 8] : 8'h00;
        m_ch[i]    = c[1:0];
        m_valid[i] = 1'b1;
        m_fs[i]    = mode && (c == 0);
        m_pos[i]   = mode ? (m_pos[i] + 1) % nc[i] : 0;
        m_wait[i]  = 0;
      end else begin
        if (!elig) m_wait[i]++;
        if (m_valid[i] && out_ready) begin
          m_valid[i] = 1'b0;
          m_fs[i]    = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("model_inst%0d", i),
            {20'h0, o_valid[i], o_fs[i], o_ch[i], o_data[i]},
            {20'h0, m_valid[i], m_fs[i], m_ch[i], m_data[i]});
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_data = 32'h4433_2211;
    model_reset();
    step(); step();
    check("reset_valid", {31'h0, o_valid[0]}, 32'h0);
    check("reset_data", {24'h0, o_data[0]}, 32'h0);
    rst_n = 1'b1;

    // Scan sequence, wrap on the 3-channel instance, dwell on the 3-cycle one.
    for (int k = 0; k < 7; k++) begin
      step();
      check("scan_ch", {30'h0, o_ch[0]}, 32'(k % 4));
      check("scan_data", {24'h0, o_data[0]}, 32'((k % 4 + 1) * 'h11));
      check("scan_fs", {31'h0, o_fs[0]}, 32'(k % 4 == 0));
      check("scan_valid", {31'h0, o_valid[0]}, 32'h1);
      check("wrap3_ch", {30'h0, o_ch[2]}, 32'(k % 3));
      check("dwell_valid", {31'h0, o_valid[1]}, 32'(k % 3 == 2));
      if (k % 3 == 2) check("dwell_ch", {30'h0, o_ch[1]}, 32'(k / 3));
    end

    // Backpressure at ch2.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_ch", {30'h0, o_ch[0]}, 32'd2);
      check("stall_data", {24'h0, o_data[0]}, 32'h33);
      check("stall_valid", {31'h0, o_valid[0]}, 32'h1);
    end
    out_ready = 1'b1;
    step();
    check("resume_ch", {30'h0, o_ch[0]}, 32'd3);
    check("resume_data", {24'h0, o_data[0]}, 32'h44);

    // Global enable low freezes everything even with ready high.
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("frozen_ch", {30'h0, o_ch[0]}, 32'd3);
      check("frozen_valid", {31'h0, o_valid[0]}, 32'h1);
    end
    ena = 1'b1;
    step();
    check("unfreeze_ch", {30'h0, o_ch[0]}, 32'd0);
    check("unfreeze_fs", {31'h0, o_fs[0]}, 32'h1);

    // Fixed mode on ch2, then back to scan starting at ch0.
    mode = 1'b0; sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      check("fixed_ch", {30'h0, o_ch[0]}, 32'd2);
      check("fixed_data", {24'h0, o_data[0]}, 32'h33);
      check("fixed_fs", {31'h0, o_fs[0]}, 32'h0);
    end
    mode = 1'b1;
    step();
    check("rescan_ch", {30'h0, o_ch[0]}, 32'd0);
    check("rescan_fs", {31'h0, o_fs[0]}, 32'h1);

    // Out-of-range select on the 3-channel instance.
    mode = 1'b0; sel = 2'd3;
    step();
    check("oor_ch", {30'h0, o_ch[2]}, 32'd3);
    check("oor_data", {24'h0, o_data[2]}, 32'h0);
    check("oor_valid", {31'h0, o_valid[2]}, 32'h1);

    // Asynchronous reset mid-beat, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'h0, o_valid[0]}, 32'h0);
    check("async_data", {24'h0, o_data[0]}, 32'h0);
    check("async_ch", {30'h0, o_ch[0]}, 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    mode = 1'b1;
    step();
    check("post_rst_valid", {31'h0, o_valid[0]}, 32'h1);
    check("post_rst_ch", {30'h0, o_ch[0]}, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      ena       = ($urandom_range(0, 7) != 0);
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_chan_mux.md
Name: tdm_chan_mux

Overview:
Parametrised, registered N-channel by W-bit time-division multiplexer for the time-multiplexed neuron datapath. It supersedes the fixed 2:1 and 4:1 8-bit combinational muxes.
- Scan mode: steps round-robin through all channels, holding each slot for a programmable dwell.
- Fixed mode: repeatedly samples one externally selected channel.
- Output: each sample is a registered beat with a valid/ready handshake, a channel tag and a frame marker, feeding the shared neuron update stage.

Parameters:
WIDTH, 8, bits per channel sample
NUM_CH, 4, number of input channels (>=2)
SLOT_CYCLES, 1, dwell cycles per slot before a capture is eligible (>=1)
CH_W, clog2(NUM_CH), derived localparam; channel index width; not overridable

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all internal state and outputs
mode  in  1  0 = fixed (use sel), 1 = round-robin scan
sel  in  CH_W  channel index used in fixed mode
in_data  in  NUM_CH*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH]
out_data  out  WIDTH  registered sample
out_ch  out  CH_W  channel index of out_data
out_valid  out  1  beat present
out_ready  in  1  consumer accepts beat when out_valid & out_ready
frame_start  out  1  high with the beat whose out_ch==0 in scan mode; 0 in fixed mode

Behaviour:
- Reset (async, rst_n low): out_data=0, out_ch=0, out_valid=0, frame_start=0, slot=0, dwell=0. A pending beat is dropped. Release is synchronous to the next clk edge.
- ena=0: no state changes, outputs hold, and a handshake is not consumed even if out_ready=1.
- Dwell counter:
  - Counts 0..SLOT_CYCLES-1 and is eligible at SLOT_CYCLES-1.
  - On capture it returns to 0.
  - If eligible but stalled, it holds at its terminal value.
- Output slot is free when !out_valid || out_ready.
- Capture occurs on an edge with ena & eligible & slot free:
  - out_data <= channel C.
  - out_ch <= C.
  - out_valid <= 1.
  - frame_start <= (mode==1 && C==0).
- Channel C:
  - Fixed mode: C = sel.
  - Scan mode: C = slot, then slot <= (slot==NUM_CH-1) ? 0 : slot+1.
- Fixed mode holds slot at 0, so entering scan mode always starts at channel 0.
- Mode and sel are sampled only at capture edges. A change between captures affects the next beat only.
- Consume without capture (valid & ready, not eligible): out_valid <= 0 and frame_start <= 0. out_data and out_ch hold their last values.
- Simultaneous consume and capture: the new beat replaces the old one in the same edge, so out_valid stays 1 and throughput is unaffected.
- Stall (out_valid & !out_ready): out_data, out_ch, out_valid and frame_start are stable. Slot does not advance.
- Latency: the sample is taken at the capture edge and is visible immediately after it.
- Throughput: with SLOT_CYCLES=1 and out_ready held high, one beat per cycle.
- Out-of-range sel (sel >= NUM_CH, non-power-of-2 NUM_CH): out_data=0 and out_ch=sel; the beat is still issued.
- Wrap-around: the slot counter never reaches NUM_CH, including non-power-of-2 values.
- No combinational path from in_data, sel or mode to any output. The only combinational path is out_ready into next-state logic.

Decomposition:
- Shared package tdm_pkg holds:
  - clog2-style width function used for CH_W;
  - mode encodings MODE_FIXED=1'b0 and MODE_SCAN=1'b1.
- One sub-module, tdm_dwell_counter: SLOT_CYCLES-parametrised counter with hold input and eligible output, reused by later neuron timing blocks.
- Channel select, slot counter and output register stay in the top module.

Test Plan:
- Reset: rst_n low mid-beat with out_valid=1 -> all outputs 0 immediately, asynchronously, before the next edge; first beat is captured on the first eligible edge after release.
- Scan, NUM_CH=4, SLOT_CYCLES=1, out_ready=1, channels 0x11/0x22/0x33/0x44:
  - out_ch runs 0,1,2,3,0 with data 0x11,0x22,0x33,0x44,0x11;
  - frame_start is high on each ch0 beat;
  - out_valid is continuously 1 from the first capture.
- Backpressure: scan, out_ready=0 for 5 cycles at ch2 -> out_data=0x33 and out_ch=2 held stable; on ready the next beat is ch3=0x44 with no channel skipped or duplicated.
- Dwell: SLOT_CYCLES=3, scan, out_ready=1 -> a capture every 3rd cycle; out_valid high 1 of 3 cycles after each capture; order 0,1,2,3.
- Fixed mode: mode=0, sel=2 -> repeated beats tagged ch2 and frame_start=0 throughout; switching to mode=1 makes the next capture ch0 with frame_start=1.
- Edge cases:
  - ena=0 for 4 cycles mid-scan with out_ready=1 -> outputs and slot frozen, no beat consumed;
  - NUM_CH=3 -> wrap 2 to 0;
  - sel=3 with NUM_CH=3 -> out_data=0, out_ch=3.
